kcore_fifo_stream_unpacker: RTL and testbench

Consumer for the read side of the kernel's 64-bit ap_fifo-style FIFOs (empty_n / read_ce / read / dout, first-word-fall-through). On a start command it pops a fixed number of 64-bit words. It splits each word into two 32-bit items (vertex/degree fields) and emits them on a valid/ready stream, flagging the last item. It sits between the edge/vertex FIFOs and the k-core update pipeline.

---
 rtl/kcore_fifo_stream_unpacker.sv | 129 ++++++++++++
 tb/tb_kcore_fifo_stream_unpacker.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kcore_fifo_stream_unpacker.sv
// Pops a commanded number of 64-bit words from an FWFT ap_fifo read port and
// streams each word as two 32-bit items (low half first), flagging the final item.
module kcore_fifo_stream_unpacker #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ITEM_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  num_words,
    output logic                  busy,
    output logic                  done,
    input  logic                  fifo_empty_n,
    output logic                  fifo_read_ce,
    output logic                  fifo_read,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ITEM_WIDTH-1:0] out_data,
    output logic                  out_last
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StEmitLo,
        StEmitHi,
        StFinish
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                r_state, w_state_next;
    logic [DATA_WIDTH-1:0] r_word, w_word_next;
    logic [CNT_WIDTH-1:0]  r_words_left, w_words_left_next;
    logic                  r_busy, r_done, r_out_valid, r_out_last;
    logic [ITEM_WIDTH-1:0] r_out_data, w_out_data_next;
    logic                  w_read, w_transfer, w_emit_next;

    assign w_transfer = r_out_valid & out_ready;

    always_comb begin
        w_state_next      = r_state;
        w_word_next       = r_word;
        w_words_left_next = r_words_left;
        w_read            = 1'b0;
        case (r_state)
            StIdle: begin
                if (start) begin
                    if (num_words == '0) begin
                        w_state_next = StFinish;
                    end else begin
                        w_words_left_next = num_words;
                        w_state_next      = StFetch;
                    end
                end
            end
            StFetch: begin
                w_read = 1'b1;
                if (fifo_empty_n) begin
                    w_word_next       = fifo_dout;
                    w_words_left_next = r_words_left - CntOne;
                    w_state_next      = StEmitLo;
                end
            end
            StEmitLo: begin
                if (w_transfer) w_state_next = StEmitHi;
            end
            StEmitHi: begin
                if (w_transfer) begin
                    if (r_words_left == '0) begin
                        w_state_next = StFinish;
                    end else if (fifo_empty_n) begin
                        // Back-to-back pop keeps one item per cycle flowing.
                        w_read            = 1'b1;
                        w_word_next       = fifo_dout;
                        w_words_left_next = r_words_left - CntOne;
                        w_state_next      = StEmitLo;
                    end else begin
                        w_state_next = StFetch;
                    end
                end
            end
            StFinish: w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
        if (reset) w_read = 1'b0;
    end

    assign w_emit_next = (w_state_next == StEmitLo) || (w_state_next == StEmitHi);

    always_comb begin
        w_out_data_next = r_out_data;
        if (w_state_next == StEmitLo) w_out_data_next = w_word_next[ITEM_WIDTH-1:0];
        if (w_state_next == StEmitHi) w_out_data_next = w_word_next[DATA_WIDTH-1:ITEM_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StIdle;
            r_word       <= '0;
            r_words_left <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_word       <= w_word_next;
            r_words_left <= w_words_left_next;
            r_busy       <= (w_state_next == StFetch) || w_emit_next;
            r_done       <= (w_state_next == StFinish);
            r_out_valid  <= w_emit_next;
            r_out_data   <= w_out_data_next;
            r_out_last   <= (w_state_next == StEmitHi) && (w_words_left_next == '0);
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign fifo_read_ce = ~reset;
    assign fifo_read    = w_read;
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_last     = r_out_last;

endmodule

// File: tb/tb_kcore_fifo_stream_unpacker.sv
// Directed bench for kcore_fifo_stream_unpacker: behavioural FWFT FIFO, a negedge
// monitor logging transfers/pops/done, and hand-computed expected item sequences.
module tb_kcore_fifo_stream_unpacker;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] num_words;
    logic        busy;
    logic        done;
    logic        fifo_empty_n;
    logic        fifo_read_ce;
    logic        fifo_read;
    logic [63:0] fifo_dout;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;

    kcore_fifo_stream_unpacker #(
        .DATA_WIDTH(64),
        .ITEM_WIDTH(32),
        .CNT_WIDTH (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .num_words   (num_words),
        .busy        (busy),
        .done        (done),
        .fifo_empty_n(fifo_empty_n),
        .fifo_read_ce(fifo_read_ce),
        .fifo_read   (fifo_read),
        .fifo_dout   (fifo_dout),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FWFT FIFO model: main process writes, posedge process pops.
    logic [63:0] mem [16];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        pop_pend = 1'b0;

    assign fifo_empty_n = (rd_ptr != wr_ptr);
    assign fifo_dout    = mem[rd_ptr % 16];

    always @(posedge clk) begin
        if (pop_pend) rd_ptr <= rd_ptr + 1;
    end

    // Monitor, sampled on the falling edge.
    logic [31:0] got_data [$];
    logic        got_last [$];
    int          pop_cnt   = 0;
    int          read_cnt  = 0;
    int          valid_cnt = 0;
    int          done_cnt  = 0;
    int          stab_err  = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    logic        prev_last  = 1'b0;

    always @(negedge clk) begin
        pop_pend = fifo_read & fifo_empty_n;
        if (pop_pend) pop_cnt++;
        if (fifo_read) read_cnt++;
        if (out_valid) valid_cnt++;
        if (done) done_cnt++;
        if (out_valid && out_ready) begin
            got_data.push_back(out_data);
            got_last.push_back(out_last);
        end
        if (prev_stall && (!out_valid || out_data != prev_data || out_last != prev_last))
            stab_err++;
        prev_stall = out_valid && !out_ready && !reset;
        prev_data  = out_data;
        prev_last  = out_last;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] w);
        mem[wr_ptr % 16] = w;
        wr_ptr++;
    endtask

    task automatic start_cmd(input logic [31:0] n);
        start     = 1'b1;
        num_words = n;
        tick();
        start     = 1'b0;
        num_words = '0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0 = done_cnt;
        int n  = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, 64'(done_cnt != d0), 64'd1);
    endtask

    // Items logged since index 'from' must be base, base+1, ... with last only at the end.
    task automatic check_log(input string tag, input int from, input logic [31:0] base,
                             input int n);
        check({tag, "_count"}, 64'(got_data.size() - from), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (from + i < got_data.size()) begin
                check($sformatf("%s_data%0d", tag, i), 64'(got_data[from+i]), 64'(base + 32'(i)));
                check($sformatf("%s_last%0d", tag, i), 64'(got_last[from+i]), 64'(i == n - 1));
            end
        end
    endtask

    int log0, pop0, done0, read0, valid0;

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        num_words = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_fifo_read", 64'(fifo_read), 64'd0);
        check("rst_read_ce", 64'(fifo_read_ce), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        reset = 1'b0;
        tick();
        check("read_ce_run", 64'(fifo_read_ce), 64'd1);

        // 1: preloaded FIFO, full-rate stream
        push(64'h00000002_00000001);
        push(64'h00000004_00000003);
        out_ready = 1'b1;
        log0 = got_data.size();
        pop0 = pop_cnt;
        start_cmd(32'd2);
        check("t1_fetch_read", 64'(fifo_read), 64'd1);
        check("t1_fetch_busy", 64'(busy), 64'd1);
        check("t1_fetch_valid", 64'(out_valid), 64'd0);
        tick();
        check("t1_item1_valid", 64'(out_valid), 64'd1);
        check("t1_item1_data", 64'(out_data), 64'd1);
        tick();
        check("t1_item2_data", 64'(out_data), 64'd2);
        check("t1_b2b_read", 64'(fifo_read), 64'd1);
        tick();
        check("t1_item3_data", 64'(out_data), 64'd3);
        check("t1_item3_last", 64'(out_last), 64'd0);
        tick();
        check("t1_item4_data", 64'(out_data), 64'd4);
        check("t1_item4_last", 64'(out_last), 64'd1);
        check("t1_item4_done", 64'(done), 64'd0);
        tick();
        check("t1_done", 64'(done), 64'd1);
        check("t1_busy_at_done", 64'(busy), 64'd0);
        check("t1_valid_at_done", 64'(out_valid), 64'd0);
        tick();
        check("t1_done_pulse", 64'(done), 64'd0);
        check("t1_pops", 64'(pop_cnt - pop0), 64'd2);
        check_log("t1", log0, 32'd1, 4);

        // 2: zero-length command
        read0  = read_cnt;
        valid0 = valid_cnt;
        start_cmd(32'd0);
        check("t2_done", 64'(done), 64'd1);
        check("t2_busy", 64'(busy), 64'd0);
        tick();
        check("t2_done_pulse", 64'(done), 64'd0);
        check("t2_no_read", 64'(read_cnt - read0), 64'd0);
        check("t2_no_valid", 64'(valid_cnt - valid0), 64'd0);

        // 3: FIFO empty at start, data arrives later
        log0 = got_data.size();
        pop0 = pop_cnt;
        start_cmd(32'd2);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t3_wait_read%0d", k), 64'(fifo_read), 64'd1);
            check($sformatf("t3_wait_valid%0d", k), 64'(out_valid), 64'd0);
            tick();
        end
        push(64'h00000002_00000001);
        tick();
        check("t3_item1_valid", 64'(out_valid), 64'd1);
        check("t3_item1_data", 64'(out_data), 64'd1);
        push(64'h00000004_00000003);
        wait_done("t3", 20);
        check("t3_pops", 64'(pop_cnt - pop0), 64'd2);
        check_log("t3", log0, 32'd1, 4);

        // 4: backpressure pattern 1,0,0,1 over three words
        push(64'h00000011_00000010);
        push(64'h00000013_00000012);
        push(64'h00000015_00000014);
        log0  = got_data.size();
        pop0  = pop_cnt;
        done0 = done_cnt;
        begin
            int s0 = stab_err;
            int c  = 0;
            start_cmd(32'd3);
            while (done_cnt == done0 && c < 80) begin
                out_ready = (c % 4 == 0) || (c % 4 == 3);
                tick();
                c++;
            end
            out_ready = 1'b1;
            tick();
            check("t4_done_seen", 64'(done_cnt - done0), 64'd1);
            check("t4_stable", 64'(stab_err - s0), 64'd0);
        end
        check("t4_pops", 64'(pop_cnt - pop0), 64'd3);
        check_log("t4", log0, 32'h10, 6);

        // 5: reset while holding the high half of word 1 of 3
        push(64'h00000021_00000020);
        push(64'h00000023_00000022);
        push(64'h00000025_00000024);
        pop0 = pop_cnt;
        start_cmd(32'd3);
        tick();
        check("t5_lo_data", 64'(out_data), 64'h20);
        tick();
        check("t5_hi_data", 64'(out_data), 64'h21);
        out_ready = 1'b0;
        reset     = 1'b1;
        #1;
        check("t5_read_in_reset", 64'(fifo_read), 64'd0);
        tick();
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_done", 64'(done), 64'd0);
        check("t5_valid", 64'(out_valid), 64'd0);
        check("t5_data", 64'(out_data), 64'd0);
        check("t5_last", 64'(out_last), 64'd0);
        check("t5_fifo_read", 64'(fifo_read), 64'd0);
        reset     = 1'b0;
        out_ready = 1'b1;
        tick();
        check("t5_pops_before", 64'(pop_cnt - pop0), 64'd1);
        check("t5_fifo_level", 64'(wr_ptr - rd_ptr), 64'd2);
        log0 = got_data.size();
        start_cmd(32'd2);
        wait_done("t5", 20);
        check("t5_pops_total", 64'(pop_cnt - pop0), 64'd3);
        check_log("t5", log0, 32'h22, 4);

        // 6: second start mid-command is ignored
        push(64'h00000031_00000030);
        push(64'h00000033_00000032);
        log0  = got_data.size();
        pop0  = pop_cnt;
        done0 = done_cnt;
        start_cmd(32'd2);
        tick();
        start     = 1'b1;
        num_words = 32'd5;
        tick();
        start     = 1'b0;
        num_words = '0;
        wait_done("t6", 20);
        repeat (6) tick();
        check("t6_single_done", 64'(done_cnt - done0), 64'd1);
        check("t6_pops", 64'(pop_cnt - pop0), 64'd2);
        check("t6_idle_busy", 64'(busy), 64'd0);
        check("t6_idle_valid", 64'(out_valid), 64'd0);
        check("t6_fifo_empty", 64'(wr_ptr - rd_ptr), 64'd0);
        check_log("t6", log0, 32'h30, 4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
